// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequential PCs from an async-read imem into a small FIFO.
// Optional fetch/flush statistics counters are built when FETCH_QUEUE_STATS_EN is defined.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [WIDTH-1:0] out_pc
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]      fetch_count,
    output logic [31:0]      flush_count
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic pop;
    logic push;
    logic full;

    // DEPTH is a power of two, so the count MSB is set exactly when the queue is full.
    assign full      = count_q[PTR_W];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign push      = ~redirect & (~full | pop);
    assign imem_addr = fetch_pc_q;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            // A pop in this cycle is still a valid handoff; the flush discards the rest.
            fetch_pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + WIDTH'(4);
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage has no reset; entries are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= imem_data;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + 32'(push);
        flush_count_d = flush_count_q + 32'(redirect);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the address and PC width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning the queue entry count; legal values are powers of two, 2 or more.
REQ-003 The module SHALL have parameter RESET_PC, default WIDTH'h0, meaning the fetch PC loaded on reset; bits [1:0] are zero.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-006 Port imem_addr, output, WIDTH bits: the current fetch PC, driven to the asynchronous-read instruction memory.
REQ-007 Port imem_data, input, 32 bits: the instruction word at imem_addr, valid in the same cycle.
REQ-008 Port redirect, input, 1 bit: a taken branch or jump from execute; flushes the queue.
REQ-009 Port redirect_pc, input, WIDTH bits: the new fetch target, sampled when redirect=1.
REQ-010 Port out_valid, output, 1 bit: the queue head holds an instruction.
REQ-011 Port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-012 Port out_instr, output, 32 bits: the head instruction word.
REQ-013 Port out_pc, output, WIDTH bits: the PC of the head instruction.

Function
REQ-014 The queue SHALL be a circular FIFO of DEPTH entries {pc, instr}, with read and write pointers that wrap modulo DEPTH and an occupancy count from 0 to DEPTH.
REQ-015 A pop SHALL occur when out_valid=1 and out_ready=1; that cycle's head is then consumed.
REQ-016 A push SHALL occur when redirect=0 and either count<DEPTH or a pop occurs in the same cycle; it writes {imem_addr, imem_data}.
REQ-017 On a push, the fetch PC SHALL advance by 4, modulo 2^WIDTH (wrap from all-ones-minus-3 to 0).
REQ-018 Without a push, the fetch PC SHALL hold.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH.
REQ-020 out_valid SHALL equal (count!=0).
REQ-021 out_instr and out_pc SHALL show the head entry, and SHALL be 0 when out_valid=0.
REQ-022 A redirect SHALL, on the next edge: set count and both pointers to 0, and load the fetch PC with {redirect_pc[WIDTH-1:2], 2'b00}. No push occurs in the redirect cycle.
REQ-023 A pop that completes in a redirect cycle SHALL count as a valid handoff; decode owns it, and the flush still empties the queue.
REQ-024 Redirect latency: the first fetch at the target SHALL be pushed in cycle R+1, with out_valid=1 and out_pc=target in cycle R+2 (R = the redirect cycle).
REQ-025 Continuous redirect=1 SHALL keep the queue empty, with the fetch PC tracking redirect_pc.
REQ-026 With out_ready held at 1 and no redirects, throughput SHALL be one instruction per cycle after the initial fill.

Reset
REQ-027 While rst=1, at each edge the block SHALL set: fetch PC=RESET_PC, count=0, pointers=0.
REQ-028 During and after reset, outputs SHALL be out_valid=0, out_instr=0, out_pc=0, and imem_addr=RESET_PC.
REQ-029 Reset SHALL take priority over redirect, push and pop.
REQ-030 Queue storage SHALL NOT be reset.
REQ-031 The first push SHALL occur in the first cycle with rst=0; out_valid rises one cycle later.
REQ-032 Reset asserted mid-operation SHALL discard all queued entries.

Configuration
REQ-033 With macro FETCH_QUEUE_STATS_EN defined, the block SHALL add two outputs, each 32 bits, zeroed by reset and wrapping at 2^32:
- fetch_count: increments on each push.
- flush_count: increments on each redirect cycle.
REQ-034 Without FETCH_QUEUE_STATS_EN, these ports and their counters SHALL NOT exist.

Verification
REQ-035 Reset then stall: RESET_PC=0x0, rst released, out_ready=0 -> pushes at PCs 0x0, 0x4, 0x8, 0xC; count=4; imem_addr holds 0x10; out_valid=1, out_pc=0x0.
REQ-036 Full with pop: queue full, out_ready=1 for one cycle -> pop of 0x0 and push of 0x10 in the same cycle; count stays 4; next out_pc=0x4.
REQ-037 Streaming: out_ready=1 constantly from reset -> out_pc sequence 0x0, 0x4, 0x8, ... on consecutive cycles from the second cycle after reset release.
REQ-038 Redirect: redirect=1, redirect_pc=0x103 while 3 entries are queued and out_ready=1 -> head popped; next cycle out_valid=0 and imem_addr=0x100; the cycle after, out_pc=0x100.
REQ-039 PC wrap and reset: WIDTH=32, redirect to 0xFFFFFFFC -> next queued PCs 0xFFFFFFFC, 0x0. Then rst=1 mid-stream -> out_valid=0 next cycle and imem_addr=RESET_PC.
REQ-040 Stats (FETCH_QUEUE_STATS_EN defined): 10 pushes and 2 redirects -> fetch_count=10 and flush_count=2; both read 0 after rst.
